// File: rtl/demux.sv
`default_nettype none
// ============================================================================
// Module   : demux
// Brief    : 1-to-2 valid/ready demultiplexer with one register stage per output
// Revision : 1.0 - initial release
// ============================================================================
module demux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             sel,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] z,
    output logic             z_valid,
    input  logic             z_ready
);

    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_z;
    logic             r_z_valid;

    logic w_y_free;
    logic w_z_free;
    logic w_accept;
    logic w_y_load;
    logic w_z_load;
    logic w_y_pop;
    logic w_z_pop;

    // A slot can take new data when it is empty or is being drained this edge.
    assign w_y_free = !r_y_valid || y_ready;
    assign w_z_free = !r_z_valid || z_ready;
    assign a_ready  = sel ? w_z_free : w_y_free;

    assign w_accept = a_valid && a_ready;
    assign w_y_load = w_accept && !sel;
    assign w_z_load = w_accept && sel;
    assign w_y_pop  = r_y_valid && y_ready;
    assign w_z_pop  = r_z_valid && z_ready;

    // Popping clears the data so an empty output never shows stale bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else if (w_y_load) begin
            r_y       <= a;
            r_y_valid <= 1'b1;
        end else if (w_y_pop) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z       <= '0;
            r_z_valid <= 1'b0;
        end else if (w_z_load) begin
            r_z       <= a;
            r_z_valid <= 1'b1;
        end else if (w_z_pop) begin
            r_z       <= '0;
            r_z_valid <= 1'b0;
        end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign z       = r_z;
    assign z_valid = r_z_valid;

endmodule
`default_nettype wire

// File: tb/tb_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux
// Brief    : self-checking bench for demux: per-cycle model compare plus literals
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic             sel;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic             z_ready;

    int n_pass  = 0;
    int n_total = 0;

    demux #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .sel     (sel),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .z       (z),
        .z_valid (z_valid),
        .z_ready (z_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: two slots indexed by output number (0 = y, 1 = z).
    logic [WIDTH-1:0] m_data  [2];
    logic             m_valid [2];

    function automatic logic model_ready(input logic s);
        logic [1:0] rdy;
        rdy = {z_ready, y_ready};
        return !m_valid[s] || rdy[s];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_data[k]  = '0;
                m_valid[k] = 1'b0;
            end
        end else begin
            logic       acc;
            logic [1:0] rdy;
            acc = a_valid && model_ready(sel);
            rdy = {z_ready, y_ready};
            for (int k = 0; k < 2; k++) begin
                if (acc && (int'(sel) == k)) begin
                    m_data[k]  = a;
                    m_valid[k] = 1'b1;
                end else if (m_valid[k] && rdy[k]) begin
                    m_data[k]  = '0;
                    m_valid[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_y",       32'(y),       32'(m_data[0]));
        chk("cmp_y_valid", 32'(y_valid), 32'(m_valid[0]));
        chk("cmp_z",       32'(z),       32'(m_data[1]));
        chk("cmp_z_valid", 32'(z_valid), 32'(m_valid[1]));
        chk("cmp_a_ready", 32'(a_ready), 32'(model_ready(sel)));
    end

    task automatic cyc(input logic av, input logic s, input logic [WIDTH-1:0] d,
                       input logic yr, input logic zr);
        a_valid = av;
        sel     = s;
        a       = d;
        y_ready = yr;
        z_ready = zr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_data[0] = '0; m_data[1] = '0; m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        rst = 1'b0; a = '0; sel = 1'b0; a_valid = 1'b0; y_ready = 1'b1; z_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_z_valid", 32'(z_valid), 32'd0);
        chk("rst_ready_sel0", 32'(a_ready), 32'd1);
        sel = 1'b1; #1;
        chk("rst_ready_sel1", 32'(a_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // First accept on the edge right after reset release.
        cyc(1, 0, 4'h0, 1, 1);
        chk("v034_y", 32'(y), 32'h0);
        chk("v034_y_valid", 32'(y_valid), 32'd1);
        chk("v034_z_valid", 32'(z_valid), 32'd0);
        cyc(1, 0, 4'h1, 1, 1);
        chk("v035_y", 32'(y), 32'h1);
        chk("v035_y_valid", 32'(y_valid), 32'd1);
        chk("v035_z", 32'(z), 32'h0);
        cyc(1, 1, 4'h0, 1, 1);
        chk("v036a_z", 32'(z), 32'h0);
        chk("v036a_z_valid", 32'(z_valid), 32'd1);
        chk("v036a_y_valid", 32'(y_valid), 32'd0);
        cyc(1, 1, 4'h1, 1, 1);
        chk("v036b_z", 32'(z), 32'h1);
        chk("v036b_z_valid", 32'(z_valid), 32'd1);
        chk("v036b_y", 32'(y), 32'h0);
        cyc(0, 0, 4'hF, 1, 1);
        chk("drain_z_valid", 32'(z_valid), 32'd0);
        chk("drain_z", 32'(z), 32'h0);

        // Held y blocks sel=0 but not sel=1.
        cyc(1, 0, 4'h1, 0, 1);
        a_valid = 1'b1; sel = 1'b0; a = 4'hA; #1;
        chk("v037_ready_blocked", 32'(a_ready), 32'd0);
        @(posedge clk); #1;
        chk("v037_y_held", 32'(y), 32'h1);
        sel = 1'b1; a = 4'h5; #1;
        chk("v037_ready_sel1", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        chk("v037_z", 32'(z), 32'h5);
        chk("v037_y_still", 32'(y), 32'h1);

        // Pop and reload of y on one edge.
        cyc(1, 0, 4'h9, 1, 0);
        chk("v038_y", 32'(y), 32'h9);
        chk("v038_y_valid", 32'(y_valid), 32'd1);
        chk("v038_z_held", 32'(z), 32'h5);

        // Sustained alternating traffic, then randomised handshakes.
        for (int i = 0; i < 8; i++) cyc(1, i[0], 4'(i + 3), 1, 1);
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Asynchronous reset between edges with both outputs full.
        cyc(1, 0, 4'h3, 0, 0);
        cyc(1, 1, 4'h7, 0, 0);
        chk("pre_rst_y", 32'(y), 32'h3);
        chk("pre_rst_z", 32'(z), 32'h7);
        #2 rst = 1'b1;
        #1;
        chk("v039_y", 32'(y), 32'h0);
        chk("v039_z", 32'(z), 32'h0);
        chk("v039_y_valid", 32'(y_valid), 32'd0);
        chk("v039_z_valid", 32'(z_valid), 32'd0);
        a_valid = 1'b1; sel = 1'b0; a = 4'hC; y_ready = 1'b1; z_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_accept", 32'(y_valid), 32'd0);
        rst = 1'b0;
        cyc(1, 0, 4'h4, 1, 1);
        chk("post_rst_y", 32'(y), 32'h4);
        chk("post_rst_y_valid", 32'(y_valid), 32'd1);
        cyc(0, 0, 4'h0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 Parameter: WIDTH, 1, data width of input and each output.
REQ-002 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 a  input  WIDTH  input data word.
REQ-006 sel  input  1  output select: 0 routes to y, 1 routes to z.
REQ-007 a_valid  input  1  a/sel hold a valid transfer this cycle.
REQ-008 a_ready  output  1  demux accepts the transfer this cycle.
REQ-009 y  output  WIDTH  output 0 data, registered.
REQ-010 y_valid  output  1  y holds valid data.
REQ-011 y_ready  input  1  downstream of y accepts data.
REQ-012 z  output  WIDTH  output 1 data, registered.
REQ-013 z_valid  output  1  z holds valid data.
REQ-014 z_ready  input  1  downstream of z accepts data.

Function
REQ-015 Each output (y, z) has one register stage: data plus valid flag; no other storage.
REQ-016 Input accept: transfer occurs on a rising clk edge when a_valid=1 and a_ready=1.
REQ-017 a_ready is combinational: (sel=0) ? (!y_valid | y_ready) : (!z_valid | z_ready); it does not depend on a_valid.
REQ-018 On accept with sel=0: y loads a and y_valid=1 next cycle; z register is unchanged.
REQ-019 On accept with sel=1: z loads a and z_valid=1 next cycle; y register is unchanged.
REQ-020 Latency: exactly 1 clk from accept to the data appearing on the selected output.
REQ-021 Output pop: y_valid=1 and y_ready=1 on an edge empties y (z likewise) unless the same edge reloads it.
REQ-022 Simultaneous pop and load of the same output: load wins; valid stays 1 and data takes the new a.
REQ-023 An empty output (valid=0) drives data all-zeros; it never shows stale data.
REQ-024 The unselected output never changes due to input activity; it only changes by its own pop.
REQ-025 A held output (valid=1, ready=0) keeps data and valid stable until popped.
REQ-026 a_valid=0: no output loads; pops proceed independently.
REQ-027 sel and a are sampled only on an accepting edge; sel changes between transfers are legal.
REQ-028 Both outputs may be valid simultaneously and pop in the same cycle.
REQ-029 Full throughput: one transfer per cycle sustained when the selected output's ready is 1.

Reset
REQ-030 rst=1 immediately forces y=0, z=0, y_valid=0, z_valid=0, independent of clk.
REQ-031 a_ready is 1 during and after reset for either sel value, since both outputs are empty.
REQ-032 Reset mid-operation discards held data; no transfer is accepted on an edge where rst=1.
REQ-033 After rst deasserts, the first accept may occur on the next rising edge.

Verification
REQ-034 y_ready=z_ready=1, a=0, sel=0, a_valid=1 -> next cycle y=0, y_valid=1, z=0, z_valid=0.
REQ-035 a=1, sel=0, a_valid=1 -> next cycle y=1, y_valid=1; z=0, z_valid=0.
REQ-036 a=0, sel=1, a_valid=1, then a=1, sel=1 -> z=0 with z_valid=1, then z=1 with z_valid=1; y=0 and y_valid=0 once popped.
REQ-037 y_ready=0, y loaded with 1, then sel=0, a_valid=1 -> a_ready=0, y holds 1; sel=1 -> a_ready=1 and z loads.
REQ-038 y full, y_ready=1, new sel=0 transfer on the same edge -> y takes the new data and y_valid stays 1.
REQ-039 rst asserted between clock edges while y and z are valid -> y=z=0 and both valids drop immediately.
